triangle_list_sequencer: RTL



---
 rtl/gfg_pkg.sv | 49 ++++
 rtl/tri_coord_clamp.sv | 29 ++
 rtl/triangle_list_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gfg_pkg.sv
// Shared register-map layout, field positions and sequencer state encodings
// for the triangle list sequencer.
package gfg_pkg;

  localparam int REG_COUNT_ADDR = 0;
  localparam int TRI_BASE_ADDR  = 1;
  localparam int TRI_STRIDE     = 2;

  localparam int COUNT_LSB = 0;
  localparam int COUNT_W   = 5;

  localparam int X_FIELD_W = 7;
  localparam int Y_FIELD_W = 6;
  localparam int COLOR_W   = 12;

  // Word A of a triangle record
  localparam int P0_X_LSB = 0;
  localparam int P0_Y_LSB = 8;
  localparam int P1_X_LSB = 16;
  localparam int P1_Y_LSB = 24;

  // Word B of a triangle record
  localparam int P2_X_LSB  = 0;
  localparam int P2_Y_LSB  = 8;
  localparam int COLOR_LSB = 16;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_RD_CNT    = 4'd1;
  localparam logic [3:0] ST_RD_A      = 4'd2;
  localparam logic [3:0] ST_RD_B      = 4'd3;
  localparam logic [3:0] ST_GO        = 4'd4;
  localparam logic [3:0] ST_WAIT_ACK  = 4'd5;
  localparam logic [3:0] ST_WAIT_DONE = 4'd6;
  localparam logic [3:0] ST_NEXT      = 4'd7;
  localparam logic [3:0] ST_FINISH    = 4'd8;

  typedef struct packed {
    logic [X_FIELD_W-1:0] p0_x;
    logic [Y_FIELD_W-1:0] p0_y;
    logic [X_FIELD_W-1:0] p1_x;
    logic [Y_FIELD_W-1:0] p1_y;
  } word_a_t;

  // word = 0 selects word A, word = 1 selects word B of triangle k
  function automatic int tri_word_addr(input int k, input int word);
    return TRI_BASE_ADDR + TRI_STRIDE * k + word;
  endfunction

endpackage

// File: rtl/tri_coord_clamp.sv
// Combinational clamp of one (x,y) vertex into the visible raster.
module tri_coord_clamp #(
  parameter int H_RES  = 80,
  parameter int V_RES  = 60,
  parameter int XW_IN  = 7,
  parameter int YW_IN  = 6,
  parameter int XW_OUT = 7,
  parameter int YW_OUT = 6
) (
  input  logic [XW_IN-1:0]  x_i,
  input  logic [YW_IN-1:0]  y_i,
  output logic [XW_OUT-1:0] x_o,
  output logic [YW_OUT-1:0] y_o
);

  always_comb begin
    if (32'(x_i) >= 32'(H_RES)) begin
      x_o = XW_OUT'(H_RES - 1);
    end else begin
      x_o = XW_OUT'(x_i);
    end
    if (32'(y_i) >= 32'(V_RES)) begin
      y_o = YW_OUT'(V_RES - 1);
    end else begin
      y_o = YW_OUT'(y_i);
    end
  end

endmodule

// File: rtl/triangle_list_sequencer.sv
// Per-frame scheduler: reads a triangle list from register RAM port B and
// hands triangles to the rasterizer one at a time with a go/done handshake.
//
// state     | meaning
// IDLE      | waiting for i_new_frame
// RD_CNT    | reading triangle count at addr 0
// RD_A      | reading word A (p0, p1) of triangle k
// RD_B      | reading word B (p2, color), then loading outputs
// GO        | one-cycle start pulse to rasterizer
// WAIT_ACK  | waiting for done to fall (bounded by ACK_TIMEOUT)
// WAIT_DONE | waiting for done to rise again
// NEXT      | advance k or finish
// FINISH    | one-cycle frame-done pulse
module triangle_list_sequencer
  import gfg_pkg::*;
#(
  parameter int HORIZ_RESOLUTION = 80,
  parameter int VERT_RESOLUTION  = 60,
  parameter int NUM_REGISTERS    = 32,
  parameter int MAX_TRIANGLES    = 15,
  parameter int READ_LATENCY     = 1,
  parameter int ACK_TIMEOUT      = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_srst,
  input  logic                                 i_new_frame,
  output logic [$clog2(NUM_REGISTERS)-1:0]     o_reg_addr,
  input  logic [31:0]                          i_reg_read_data,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0]  o_tri_p0_x,
  output logic [$clog2(VERT_RESOLUTION)-1:0]   o_tri_p0_y,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0]  o_tri_p1_x,
  output logic [$clog2(VERT_RESOLUTION)-1:0]   o_tri_p1_y,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0]  o_tri_p2_x,
  output logic [$clog2(VERT_RESOLUTION)-1:0]   o_tri_p2_y,
  output logic [11:0]                          o_tri_color,
  output logic                                 o_raster_go,
  input  logic                                 i_raster_done,
  output logic                                 o_busy,
  output logic                                 o_frame_done,
  output logic [3:0]                           o_tri_index,
  output logic                                 o_overrun
);

  localparam int AW = $clog2(NUM_REGISTERS);
  localparam int XW = $clog2(HORIZ_RESOLUTION);
  localparam int YW = $clog2(VERT_RESOLUTION);
  localparam int TW = $clog2(ACK_TIMEOUT + READ_LATENCY + 1);

  logic [3:0]         state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [3:0]         k_q, k_d;
  word_a_t            hold_a_q, hold_a_d;
  logic [XW-1:0]      p0_x_q, p0_x_d, p1_x_q, p1_x_d, p2_x_q, p2_x_d;
  logic [YW-1:0]      p0_y_q, p0_y_d, p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               overrun_q, overrun_d;

  logic [XW-1:0]      p0_x_cl, p1_x_cl, p2_x_cl;
  logic [YW-1:0]      p0_y_cl, p1_y_cl, p2_y_cl;
  logic [COUNT_W-1:0] cnt_raw, cnt_clamped;
  logic [3:0]         k_inc;
  word_a_t            word_a_rd;
  logic               unused_rd_bits;

  assign unused_rd_bits = ^i_reg_read_data;

  assign cnt_raw     = i_reg_read_data[COUNT_LSB +: COUNT_W];
  assign cnt_clamped = (cnt_raw > COUNT_W'(MAX_TRIANGLES)) ? COUNT_W'(MAX_TRIANGLES) : cnt_raw;
  assign k_inc       = k_q + 4'd1;

  assign word_a_rd.p0_x = i_reg_read_data[P0_X_LSB +: X_FIELD_W];
  assign word_a_rd.p0_y = i_reg_read_data[P0_Y_LSB +: Y_FIELD_W];
  assign word_a_rd.p1_x = i_reg_read_data[P1_X_LSB +: X_FIELD_W];
  assign word_a_rd.p1_y = i_reg_read_data[P1_Y_LSB +: Y_FIELD_W];

  // p0/p1 come from the captured word A, p2 straight from the word B read
  tri_coord_clamp #(
    .H_RES(HORIZ_RESOLUTION), .V_RES(VERT_RESOLUTION),
    .XW_IN(X_FIELD_W), .YW_IN(Y_FIELD_W), .XW_OUT(XW), .YW_OUT(YW)
  ) u_clamp_p0 (
    .x_i(hold_a_q.p0_x), .y_i(hold_a_q.p0_y), .x_o(p0_x_cl), .y_o(p0_y_cl)
  );

  tri_coord_clamp #(
    .H_RES(HORIZ_RESOLUTION), .V_RES(VERT_RESOLUTION),
    .XW_IN(X_FIELD_W), .YW_IN(Y_FIELD_W), .XW_OUT(XW), .YW_OUT(YW)
  ) u_clamp_p1 (
    .x_i(hold_a_q.p1_x), .y_i(hold_a_q.p1_y), .x_o(p1_x_cl), .y_o(p1_y_cl)
  );

  tri_coord_clamp #(
    .H_RES(HORIZ_RESOLUTION), .V_RES(VERT_RESOLUTION),
    .XW_IN(X_FIELD_W), .YW_IN(Y_FIELD_W), .XW_OUT(XW), .YW_OUT(YW)
  ) u_clamp_p2 (
    .x_i(i_reg_read_data[P2_X_LSB +: X_FIELD_W]),
    .y_i(i_reg_read_data[P2_Y_LSB +: Y_FIELD_W]),
    .x_o(p2_x_cl), .y_o(p2_y_cl)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    timer_d   = timer_q;
    count_d   = count_q;
    k_d       = k_q;
    hold_a_d  = hold_a_q;
    p0_x_d    = p0_x_q;
    p0_y_d    = p0_y_q;
    p1_x_d    = p1_x_q;
    p1_y_d    = p1_y_q;
    p2_x_d    = p2_x_q;
    p2_y_d    = p2_y_q;
    color_d   = color_q;
    overrun_d = overrun_q | (i_new_frame && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (i_new_frame) begin
          addr_d  = AW'(REG_COUNT_ADDR);
          timer_d = TW'(READ_LATENCY);
          state_d = ST_RD_CNT;
        end
      end
      ST_RD_CNT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          count_d = cnt_clamped;
          if (cnt_clamped == '0) begin
            state_d = ST_FINISH;
          end else begin
            k_d     = 4'd0;
            addr_d  = AW'(tri_word_addr(0, 0));
            timer_d = TW'(READ_LATENCY);
            state_d = ST_RD_A;
          end
        end
      end
      ST_RD_A: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          hold_a_d = word_a_rd;
          addr_d   = AW'(tri_word_addr(int'(k_q), 1));
          timer_d  = TW'(READ_LATENCY);
          state_d  = ST_RD_B;
        end
      end
      ST_RD_B: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          p0_x_d  = p0_x_cl;
          p0_y_d  = p0_y_cl;
          p1_x_d  = p1_x_cl;
          p1_y_d  = p1_y_cl;
          p2_x_d  = p2_x_cl;
          p2_y_d  = p2_y_cl;
          color_d = i_reg_read_data[COLOR_LSB +: COLOR_W];
          state_d = ST_GO;
        end
      end
      ST_GO: begin
        timer_d = TW'(ACK_TIMEOUT - 1);
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // a rasterizer that never drops done is treated as having finished
        if (!i_raster_done) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == '0) begin
          state_d = ST_NEXT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (i_raster_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (COUNT_W'(k_inc) == count_q) begin
          state_d = ST_FINISH;
        end else begin
          k_d     = k_inc;
          addr_d  = AW'(tri_word_addr(int'(k_inc), 0));
          timer_d = TW'(READ_LATENCY);
          state_d = ST_RD_A;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      timer_q   <= '0;
      count_q   <= '0;
      k_q       <= '0;
      hold_a_q  <= '0;
      p0_x_q    <= '0;
      p0_y_q    <= '0;
      p1_x_q    <= '0;
      p1_y_q    <= '0;
      p2_x_q    <= '0;
      p2_y_q    <= '0;
      color_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      k_q       <= k_d;
      hold_a_q  <= hold_a_d;
      p0_x_q    <= p0_x_d;
      p0_y_q    <= p0_y_d;
      p1_x_q    <= p1_x_d;
      p1_y_q    <= p1_y_d;
      p2_x_q    <= p2_x_d;
      p2_y_q    <= p2_y_d;
      color_q   <= color_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_reg_addr   = addr_q;
  assign o_tri_p0_x   = p0_x_q;
  assign o_tri_p0_y   = p0_y_q;
  assign o_tri_p1_x   = p1_x_q;
  assign o_tri_p1_y   = p1_y_q;
  assign o_tri_p2_x   = p2_x_q;
  assign o_tri_p2_y   = p2_y_q;
  assign o_tri_color  = color_q;
  assign o_raster_go  = (state_q == ST_GO);
  assign o_busy       = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign o_frame_done = (state_q == ST_FINISH);
  assign o_tri_index  = k_q;
  assign o_overrun    = overrun_q;

endmodule
